// File: rtl/trigger_srl_loader.sv
// Serial programmer for the SRLC32E trigger lookup tables: encodes per-channel
// condition codes into 32-entry truth tables and shifts them in, address 31 first.
module trigger_srl_loader #(
  parameter int CHANNELS = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  input  logic [3*CHANNELS-1:0]   cfg_cond,
  output logic                    srl_ce,
  output logic [CHANNELS/2-1:0]   srl_din,
  output logic                    busy,
  output logic                    done
);

  localparam int NUM_SRL = CHANNELS / 2;

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t                state, state_nxt;
  logic [4:0]            idx, idx_nxt;
  logic [3*CHANNELS-1:0] cond_q, cond_nxt;
  logic [NUM_SRL-1:0]    din_nxt;
  logic                  accept;

  function automatic logic cond_match(input logic [2:0] code, input logic old_v,
                                      input logic cur_v);
    case (code)
      3'd0:    return 1'b1;
      3'd1:    return !cur_v;
      3'd2:    return cur_v;
      3'd3:    return !old_v && cur_v;
      3'd4:    return old_v && !cur_v;
      3'd5:    return old_v != cur_v;
      3'd6:    return old_v == cur_v;
      default: return 1'b0;
    endcase
  endfunction

  // SRL address is {0, old_hi, cur_hi, old_lo, cur_lo}; the upper half never matches.
  function automatic logic table_bit(input logic [2:0] code_lo, input logic [2:0] code_hi,
                                     input logic [4:0] addr);
    if (addr[4])
      return 1'b0;
    return cond_match(code_lo, addr[1], addr[0]) && cond_match(code_hi, addr[3], addr[2]);
  endfunction

  assign accept = cfg_valid && cfg_ready;

  always_ff @(posedge clk) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = LOAD;
      LOAD:    if (idx == 5'd0) state_nxt = DONE;
      DONE:    state_nxt = accept ? LOAD : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cfg_ready = (state != LOAD);
    busy      = (state == LOAD);
    done      = (state == DONE);
  end

  // The bit for the address presented next cycle is computed ahead so din stays registered.
  always_comb begin
    idx_nxt  = idx;
    cond_nxt = cond_q;
    din_nxt  = '0;
    if (accept) begin
      idx_nxt  = 5'd31;
      cond_nxt = cfg_cond;
    end else if (state == LOAD && idx != 5'd0) begin
      idx_nxt = idx - 5'd1;
    end
    for (int k = 0; k < NUM_SRL; k++)
      din_nxt[k] = table_bit(cond_nxt[6*k +: 3], cond_nxt[6*k+3 +: 3], idx_nxt);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx     <= 5'd0;
      cond_q  <= '0;
      srl_ce  <= 1'b0;
      srl_din <= '0;
    end else begin
      idx     <= idx_nxt;
      cond_q  <= cond_nxt;
      srl_ce  <= (state_nxt == LOAD);
      srl_din <= (state_nxt == LOAD) ? din_nxt : '0;
    end
  end

endmodule

// File: tb/tb_trigger_srl_loader.sv
// Bench for trigger_srl_loader: a 2-channel and a 4-channel instance share one
// stimulus stream, each feeding behavioural SRLC32E models checked via a scoreboard.
module tb_trigger_srl_loader;

  typedef struct {
    logic [31:0] e2;
    logic [31:0] e4a;
    logic [31:0] e4b;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_valid = 1'b0;
  logic [11:0] cfg_cond = '0;

  logic       cfg_ready2, srl_ce2, busy2, done2;
  logic [0:0] srl_din2;
  logic       cfg_ready4, srl_ce4, busy4, done4;
  logic [1:0] srl_din4;

  logic [31:0] srl2 = '0, srl4a = '0, srl4b = '0;
  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          ce_run = 0;

  trigger_srl_loader #(.CHANNELS(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready2),
    .cfg_cond(cfg_cond[5:0]), .srl_ce(srl_ce2), .srl_din(srl_din2),
    .busy(busy2), .done(done2)
  );

  trigger_srl_loader #(.CHANNELS(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready4),
    .cfg_cond(cfg_cond), .srl_ce(srl_ce4), .srl_din(srl_din4),
    .busy(busy4), .done(done4)
  );

  always #5 clk = ~clk;

  // Behavioural SRLC32E: each enabled edge shifts din in at address 0.
  always @(posedge clk) begin
    if (srl_ce2) srl2 <= {srl2[30:0], srl_din2[0]};
    if (srl_ce4) begin
      srl4a <= {srl4a[30:0], srl_din4[0]};
      srl4b <= {srl4b[30:0], srl_din4[1]};
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Truth vector over {old,cur} for one channel's condition code.
  function automatic logic [3:0] chan_vec(input logic [2:0] code);
    case (code)
      3'd0:    return 4'b1111;
      3'd1:    return 4'b0101;
      3'd2:    return 4'b1010;
      3'd3:    return 4'b0010;
      3'd4:    return 4'b0100;
      3'd5:    return 4'b0110;
      3'd6:    return 4'b1001;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] model_table(input logic [2:0] c_lo, input logic [2:0] c_hi);
    logic [31:0] t;
    logic [3:0]  vlo, vhi;
    t   = '0;
    vlo = chan_vec(c_lo);
    vhi = chan_vec(c_hi);
    for (int a = 0; a < 16; a++)
      t[a] = vlo[a % 4] & vhi[a / 4];
    return t;
  endfunction

  function automatic logic [11:0] pk(input logic [2:0] c0, input logic [2:0] c1,
                                     input logic [2:0] c2, input logic [2:0] c3);
    return {c3, c2, c1, c0};
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      ce_run = 0;
    end else begin
      if (srl_ce4) begin
        ce_run++;
      end else if (ce_run != 0) begin
        checkOutput("ce_run_length", ce_run, 32);
        ce_run = 0;
      end
      if (done4) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_done", done4, 1'b0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          checkOutput("srl_2ch", srl2, e.e2);
          checkOutput("srl_4ch_0", srl4a, e.e4a);
          checkOutput("srl_4ch_1", srl4b, e.e4b);
          checkOutput("done_2ch_sync", done2, done4);
        end
      end
    end
  end

  task automatic applyStimulus(input logic [11:0] cond, input bit hold, output logic acc_in_done);
    exp_t e;
    bit   ok;
    ok = 0;
    acc_in_done = 1'b0;
    @(negedge clk);
    cfg_valid = 1'b1;
    cfg_cond  = cond;
    for (int n = 0; n < 100; n++) begin
      if (cfg_ready4) begin
        e.e2  = model_table(cond[2:0], cond[5:3]);
        e.e4a = e.e2;
        e.e4b = model_table(cond[8:6], cond[11:9]);
        acc_in_done = done4;
        sb.push_back(e);
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) checkOutput("accept_timeout", cfg_ready4, 1'b1);
    @(posedge clk);
    #1;
    if (!hold) cfg_valid = 1'b0;
  endtask

  task automatic waitDone();
    bit ok;
    ok = 0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      #1;
      if (sb.size() == 0) begin
        ok = 1;
        break;
      end
    end
    if (!ok) checkOutput("done_timeout", sb.size(), 0);
  endtask

  initial begin
    logic d;
    cfg_valid = 1'b1;
    rst_n     = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("rst_ready", cfg_ready4, 1'b1);
      checkOutput("rst_ce", {srl_ce4, srl_ce2}, 2'b00);
      checkOutput("rst_din", {srl_din4, srl_din2}, 3'b000);
      checkOutput("rst_done_busy", {done4, busy4, done2, busy2}, 4'b0000);
    end
    cfg_valid = 1'b0;
    rst_n     = 1'b1;
    @(negedge clk);
    checkOutput("no_accept_in_reset", srl_ce4, 1'b0);

    applyStimulus(pk(3'd3, 3'd0, 3'd0, 3'd0), 0, d);
    waitDone();
    checkOutput("rising_dc", srl2, 32'h00002222);

    applyStimulus(pk(3'd2, 3'd2, 3'd0, 3'd0), 0, d);
    waitDone();
    checkOutput("high_high", srl2, 32'h0000A0A0);

    applyStimulus(pk(3'd0, 3'd0, 3'd0, 3'd0), 0, d);
    waitDone();
    checkOutput("all_dc", srl2, 32'h0000FFFF);

    applyStimulus(pk(3'd0, 3'd7, 3'd7, 3'd0), 0, d);
    waitDone();
    checkOutput("never_2ch", srl2, 32'h00000000);
    checkOutput("never_4ch", srl4b, 32'h00000000);

    applyStimulus(pk(3'd3, 3'd0, 3'd0, 3'd0), 1, d);
    applyStimulus(pk(3'd4, 3'd0, 3'd0, 3'd0), 0, d);
    checkOutput("b2b_accept_in_done", d, 1'b1);
    waitDone();
    checkOutput("b2b_falling", srl2, 32'h00004444);

    applyStimulus(pk(3'd2, 3'd1, 3'd5, 3'd6), 0, d);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    sb.delete();
    @(negedge clk);
    checkOutput("abort_ce", srl_ce4, 1'b0);
    checkOutput("abort_ready", cfg_ready4, 1'b1);
    checkOutput("abort_done_busy", {done4, busy4}, 2'b00);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    applyStimulus(pk(3'd3, 3'd0, 3'd0, 3'd1), 0, d);
    waitDone();
    checkOutput("4ch_srl0", srl4a, 32'h00002222);
    checkOutput("4ch_srl1", srl4b, 32'h00000F0F);

    for (int r = 0; r < 4; r++) begin
      applyStimulus(12'($urandom), 0, d);
      waitDone();
    end

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/trigger_srl_loader.md
# trigger_srl_loader

Serial programmer for the SRLC32E-based edge/level trigger lookup tables. It takes a per-channel trigger-condition word over a valid/ready handshake and encodes it into a 32-entry truth table. It then shifts that table into one SRLC32E per channel pair through each SRL's D/CE pins, so triggers can be reconfigured at run time. It sits between the host configuration path and the trigger SRLs, whose address is {1'b0, old[2k+1], current[2k+1], old[2k], current[2k]}.

## Interface
- CHANNELS, 2: number of probed channels; must be even; NUM_SRL = CHANNELS/2.
- clk  in  1  sampling/logic clock; SRLs are clocked by the same clk.
- rst_n  in  1  synchronous, active-low reset.
- cfg_valid  in  1  new condition word offered.
- cfg_ready  out  1  block idle, accepts cfg_cond.
- cfg_cond  in  3*CHANNELS  condition code per channel; channel c uses bits [3c+2:3c].
- srl_ce  out  1  shift enable, common to all SRLs.
- srl_din  out  NUM_SRL  serial data; bit k feeds SRL k (channels 2k, 2k+1).
- busy  out  1  SRL contents invalid; trigger logic must mask matches while high.
- done  out  1  one-cycle pulse, load complete.

## Operation
- Condition codes, evaluated on (old, cur):
  - 0: don't care (always 1).
  - 1: low (cur=0).
  - 2: high (cur=1).
  - 3: rising (old=0, cur=1).
  - 4: falling (old=1, cur=0).
  - 5: change (old≠cur).
  - 6: stable (old=cur).
  - 7: never (always 0).
- Table bit for SRL k at address a (0..31):
  - For a<16: match(code[2k], cur=a[0], old=a[1]) AND match(code[2k+1], cur=a[2], old=a[3]).
  - For a≥16: 0.
- Shift order is address 31 first, down to address 0. After 32 shifts, the bit written last sits at address 0 and the first at address 31.
- Bit generation is combinational from the latched codes and a 5-bit down-counter idx; srl_din and srl_ce are registered.
- FSM states:
  - IDLE: cfg_ready=1, busy=0. When cfg_valid&cfg_ready, latch cfg_cond, set idx=31 and go to LOAD.
  - LOAD: srl_ce=1; srl_din[k] = table_k[idx]; idx decrements each cycle. After the idx=0 bit has been presented for one cycle, go to DONE.
  - DONE: one cycle with done=1 and cfg_ready=1, then return to IDLE. A handshake in DONE is accepted exactly as in IDLE.
- cfg_valid while cfg_ready=0 is ignored. cfg_cond is don't-care except at the accept edge.
- Reset values: cfg_ready=1, srl_ce=0, srl_din=0, busy=0, done=0, state=IDLE, idx=0.
- Reset mid-LOAD: outputs return to reset values at the next edge. SRL contents are then partial and undefined, and the host must reload.

## Timing
- Accept at edge A (cfg_valid&cfg_ready sampled high).
- Cycles A→A+32: srl_ce=1, busy=1, cfg_ready=0. The SRL performs exactly 32 shifts, at edges A+1..A+32, and din during cycle i (i=0..31 after A) is table[31−i].
- Cycle A+32→A+33: srl_ce=0, done=1, busy=0, cfg_ready=1.
- Earliest next accept is edge A+33, so there is a one-cycle srl_ce gap between back-to-back loads.
- srl_ce is never high for more or fewer than 32 consecutive edges per load, except when reset aborts the load.
- Latency from accept to table valid is 33 cycles; throughput is one load per 33 cycles.

## Test plan
- Reset: hold rst_n=0 for 3 cycles with cfg_valid=1 -> cfg_ready=1, srl_ce=0, srl_din=0, done=0, busy=0, and no accept while in reset.
- CHANNELS=2, ch0=rising(3), ch1=don't care(0) -> behavioural SRLC32E model holds 32'h00002222 after done; srl_ce high for exactly 32 edges.
- ch0=high(2), ch1=high(2) -> SRL = 32'h0000A0A0; all don't care -> 32'h0000FFFF; any channel never(7) -> 32'h00000000.
- Back-to-back: cfg_valid held high, first cfg rising/dc, second falling(4)/dc -> second accept in the done cycle; one-cycle srl_ce gap; final SRL = 32'h00004444.
- Reset mid-load: assert rst_n=0 at the 10th LOAD cycle -> next edge srl_ce=0, cfg_ready=1, no done pulse; a subsequent full load yields the correct table.
- CHANNELS=4: codes ch0=rising, ch1=dc, ch2=dc, ch3=low(1) -> SRL0 = 32'h00002222, SRL1 = 32'h00000F0F, both loaded in the same 32 edges.
